// File: rtl/pf_clk_div_delay_ctrl.sv
// rtl/pf_clk_div_delay_ctrl.sv - LVDS RX delay-tap / bit-slip training controller (optional centering: PF_CDD_CTRL_CENTER_EN)
module pf_clk_div_delay_ctrl #(
    parameter int                    DATA_WIDTH     = 8,
    parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN  = 8'hB4,
    parameter int                    MAX_TAPS       = 128,
    parameter int                    RST_CYCLES     = 8,
    parameter int                    SETTLE_CYCLES  = 16,
    parameter int                    COMPARE_CYCLES = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic [DATA_WIDTH-1:0] RX_DATA,
    input  logic                  DELAY_LINE_OUT_OF_RANGE,
    output logic                  CDD_RST_N,
    output logic                  DELAY_LINE_LOAD,
    output logic                  DELAY_LINE_MOVE,
    output logic                  DELAY_LINE_DIR,
    output logic                  BIT_SLIP,
    output logic [7:0]            TAP_COUNT,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERROR
);

    localparam int TAP_W  = 8;
    localparam int CNT_W  = $clog2(RST_CYCLES + SETTLE_CYCLES + COMPARE_CYCLES + 1);
    localparam int SLIP_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [TAP_W-1:0]  TAP_LAST    = TAP_W'(MAX_TAPS - 1);
    localparam logic [SLIP_W-1:0] SLIP_LAST   = SLIP_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]  RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CMP_LAST    = CNT_W'(COMPARE_CYCLES - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CDD_RST,
        ST_LOAD,
        ST_SETTLE,
        ST_COMPARE,
        ST_SLIP,
        ST_MOVE,
        ST_DONE,
        ST_ERROR
`ifdef PF_CDD_CTRL_CENTER_EN
        ,
        ST_SCAN,
        ST_BACK
`endif
    } state_t;

    state_t             state_q, state_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [SLIP_W-1:0]  slip_cnt_q, slip_cnt_n;
    logic [TAP_W-1:0]   tap_q, tap_n;
    logic               cdd_rst_n_q, cdd_rst_n_n;
    logic               load_q, load_n;
    logic               move_q, move_n;
    logic               dir_q, dir_n;
    logic               bit_slip_q, bit_slip_n;
    logic               busy_q, busy_n;
    logic               done_q, done_n;
    logic               error_q, error_n;
    logic               oor_chk_q;

`ifdef PF_CDD_CTRL_CENTER_EN
    logic               scan_q, scan_n;
    logic               back_q, back_n;
    logic [TAP_W-1:0]   t_lo_q, t_lo_n;
    logic [TAP_W-1:0]   t_hi_q, t_hi_n;
    logic [TAP_W-1:0]   back_target;
    logic               back_step;

    // Centre of the passing window; the walk back stops when the tap reaches it.
    assign back_target = t_lo_q + ((t_hi_q - t_lo_q) >> 1);
    assign back_step   = (tap_q != back_target);
`endif

    // Next state and next value of every registered output; pulses default low.
    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        slip_cnt_n  = slip_cnt_q;
        tap_n       = tap_q;
        cdd_rst_n_n = 1'b1;
        load_n      = 1'b0;
        move_n      = 1'b0;
        dir_n       = dir_q;
        bit_slip_n  = 1'b0;
        busy_n      = busy_q;
        done_n      = done_q;
        error_n     = error_q;
`ifdef PF_CDD_CTRL_CENTER_EN
        scan_n      = scan_q;
        back_n      = back_q;
        t_lo_n      = t_lo_q;
        t_hi_n      = t_hi_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (START) begin
                    state_n     = ST_CDD_RST;
                    cnt_n       = '0;
                    slip_cnt_n  = '0;
                    cdd_rst_n_n = 1'b0;
                    busy_n      = 1'b1;
                    done_n      = 1'b0;
                    error_n     = 1'b0;
`ifdef PF_CDD_CTRL_CENTER_EN
                    scan_n      = 1'b0;
                    back_n      = 1'b0;
`endif
                end
            end
            ST_CDD_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_n = ST_LOAD;
                    cnt_n   = '0;
                    load_n  = 1'b1;
                    tap_n   = '0;
                end else begin
                    cnt_n       = cnt_q + CNT_W'(1);
                    cdd_rst_n_n = 1'b0;
                end
            end
            ST_LOAD: begin
                state_n = ST_SETTLE;
                cnt_n   = '0;
            end
            ST_SETTLE: begin
                if (oor_chk_q && DELAY_LINE_OUT_OF_RANGE) begin
                    state_n = ST_ERROR;
                    busy_n  = 1'b0;
                    error_n = 1'b1;
                end else if (cnt_q == SETTLE_LAST) begin
                    cnt_n = '0;
`ifdef PF_CDD_CTRL_CENTER_EN
                    if (back_q) begin
                        state_n = ST_BACK;
                        if (back_step) begin
                            move_n = 1'b1;
                            dir_n  = 1'b0;
                            tap_n  = tap_q - TAP_W'(1);
                        end
                    end else begin
                        state_n = ST_COMPARE;
                    end
`else
                    state_n = ST_COMPARE;
`endif
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            ST_COMPARE: begin
                if (RX_DATA == TRAIN_PATTERN) begin
                    if (cnt_q == CMP_LAST) begin
                        cnt_n = '0;
`ifdef PF_CDD_CTRL_CENTER_EN
                        if (!scan_q) begin
                            t_lo_n = tap_q;
                        end
                        t_hi_n  = tap_q;
                        scan_n  = 1'b1;
                        state_n = ST_SCAN;
                        if (tap_q != TAP_LAST) begin
                            move_n = 1'b1;
                            dir_n  = 1'b1;
                            tap_n  = tap_q + TAP_W'(1);
                        end
`else
                        state_n = ST_DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
`endif
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_n = '0;
`ifdef PF_CDD_CTRL_CENTER_EN
                    if (scan_q) begin
                        state_n = ST_BACK;
                        scan_n  = 1'b0;
                        back_n  = 1'b1;
                        if (back_step) begin
                            move_n = 1'b1;
                            dir_n  = 1'b0;
                            tap_n  = tap_q - TAP_W'(1);
                        end
                    end else begin
`else
                    begin
`endif
                        state_n    = ST_SLIP;
                        bit_slip_n = (slip_cnt_q != SLIP_LAST);
                    end
                end
            end
            ST_SLIP: begin
                if (bit_slip_q) begin
                    slip_cnt_n = slip_cnt_q + SLIP_W'(1);
                    state_n    = ST_SETTLE;
                end else begin
                    slip_cnt_n = '0;
                    state_n    = ST_MOVE;
                    if (tap_q != TAP_LAST) begin
                        move_n = 1'b1;
                        dir_n  = 1'b1;
                        tap_n  = tap_q + TAP_W'(1);
                    end
                end
            end
            ST_MOVE: begin
                if (move_q) begin
                    state_n = ST_SETTLE;
                end else begin
                    state_n = ST_ERROR;
                    busy_n  = 1'b0;
                    error_n = 1'b1;
                end
            end
`ifdef PF_CDD_CTRL_CENTER_EN
            ST_SCAN: begin
                if (move_q) begin
                    state_n = ST_SETTLE;
                end else begin
                    state_n = ST_BACK;
                    scan_n  = 1'b0;
                    back_n  = 1'b1;
                    if (back_step) begin
                        move_n = 1'b1;
                        dir_n  = 1'b0;
                        tap_n  = tap_q - TAP_W'(1);
                    end
                end
            end
            ST_BACK: begin
                if (move_q) begin
                    state_n = ST_SETTLE;
                end else begin
                    state_n = ST_DONE;
                    back_n  = 1'b0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
`endif
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any training in progress.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            slip_cnt_q  <= '0;
            tap_q       <= '0;
            cdd_rst_n_q <= 1'b1;
            load_q      <= 1'b0;
            move_q      <= 1'b0;
            dir_q       <= 1'b0;
            bit_slip_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            oor_chk_q   <= 1'b0;
`ifdef PF_CDD_CTRL_CENTER_EN
            scan_q      <= 1'b0;
            back_q      <= 1'b0;
            t_lo_q      <= '0;
            t_hi_q      <= '0;
`endif
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            slip_cnt_q  <= slip_cnt_n;
            tap_q       <= tap_n;
            cdd_rst_n_q <= cdd_rst_n_n;
            load_q      <= load_n;
            move_q      <= move_n;
            dir_q       <= dir_n;
            bit_slip_q  <= bit_slip_n;
            busy_q      <= busy_n;
            done_q      <= done_n;
            error_q     <= error_n;
            // Range flag is only meaningful in the cycle right after a MOVE pulse.
            oor_chk_q   <= move_q;
`ifdef PF_CDD_CTRL_CENTER_EN
            scan_q      <= scan_n;
            back_q      <= back_n;
            t_lo_q      <= t_lo_n;
            t_hi_q      <= t_hi_n;
`endif
        end
    end

    assign CDD_RST_N       = cdd_rst_n_q;
    assign DELAY_LINE_LOAD = load_q;
    assign DELAY_LINE_MOVE = move_q;
    assign DELAY_LINE_DIR  = dir_q;
    assign BIT_SLIP        = bit_slip_q;
    assign TAP_COUNT       = tap_q;
    assign BUSY            = busy_q;
    assign DONE            = done_q;
    assign ERROR           = error_q;

endmodule

// File: tb/tb_pf_clk_div_delay_ctrl.sv
// tb/tb_pf_clk_div_delay_ctrl.sv - randomized self-checking bench for pf_clk_div_delay_ctrl
module tb_pf_clk_div_delay_ctrl;

    localparam logic [7:0] PAT    = 8'hB4;
    localparam int         MAXT   = 128;
    localparam int         BUDGET = 25000;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       oor;
    logic [7:0] rx = 8'h00;
    logic       cdd_rst_n, load, move, dir, slip, busy, done, error;
    logic [7:0] tap;

    pf_clk_div_delay_ctrl dut (
        .CLK                     (clk),
        .RESET                   (rst),
        .START                   (start),
        .RX_DATA                 (rx),
        .DELAY_LINE_OUT_OF_RANGE (oor),
        .CDD_RST_N               (cdd_rst_n),
        .DELAY_LINE_LOAD         (load),
        .DELAY_LINE_MOVE         (move),
        .DELAY_LINE_DIR          (dir),
        .BIT_SLIP                (slip),
        .TAP_COUNT               (tap),
        .BUSY                    (busy),
        .DONE                    (done),
        .ERROR                   (error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Channel model: a tap window where the word is a rotation of the pattern
    // (rotation advanced by every BIT_SLIP), random non-pattern noise elsewhere.
    int win_lo = 0, win_hi = 127, rot_off = 0;
    int ch_tap = 0, ch_slips = 0;
    int n_load = 0, n_up = 0, n_down = 0, n_slip = 0, n_rstlow = 0, n_bad = 0;

    function automatic logic [7:0] rotl(input int k);
        logic [7:0] p;
        p = PAT;
        return (p << k) | (p >> (8 - k));
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if ((int'(load) + int'(move) + int'(slip)) > 1 || (done && error)) n_bad++;
            if (!cdd_rst_n) n_rstlow++;
            if (load) begin
                n_load++;
                ch_tap = 0;
            end
            if (move) begin
                if (dir) begin
                    n_up++;
                    ch_tap++;
                end else begin
                    n_down++;
                    ch_tap--;
                end
            end
            if (slip) begin
                n_slip++;
                ch_slips++;
            end
        end
        if (ch_tap >= win_lo && ch_tap <= win_hi) begin
            rx = rotl((rot_off + ch_slips) % 8);
        end else begin
            rx = 8'($urandom);
            if (rx == PAT) rx = ~PAT;
        end
    end

    // Reference outcome: search taps in order, slip positions within a tap;
    // slips accumulate across taps (DATA_WIDTH-1 per exhausted tap).
    task automatic model(input int lo, input int hi, input int r0, input logic oor_on,
                         output logic e_done, output int e_tap, output int e_up,
                         output int e_down, output int e_slip, output int e_cyc);
        int t_lo;
        int p_lo;
        t_lo = -1;
        p_lo = 0;
        for (int t = 0; t < MAXT && t_lo < 0; t++) begin
            for (int p = 0; p < 8 && t_lo < 0; p++) begin
                if (t >= lo && t <= hi && ((r0 + 7 * t + p) % 8) == 0) begin
                    t_lo = t;
                    p_lo = p;
                end
            end
        end
        e_down = 0;
        if (t_lo < 0) begin
            e_done = 1'b0;
            e_tap  = MAXT - 1;
            e_up   = MAXT - 1;
            e_slip = 7 * MAXT;
            e_cyc  = 25 + 18 * (8 * MAXT - 1) + (MAXT - 1) + 3;
        end else begin
            e_done = 1'b1;
            e_slip = 7 * t_lo + p_lo;
            e_up   = t_lo;
            e_tap  = t_lo;
            e_cyc  = 57 + 18 * (8 * t_lo + p_lo) + t_lo;
`ifdef PF_CDD_CTRL_CENTER_EN
            begin
                int t_hi;
                int t_end;
                t_hi = t_lo;
                while (t_hi < MAXT - 1 && t_hi + 1 <= hi) t_hi++;
                t_end  = (t_hi == MAXT - 1) ? t_hi : t_hi + 1;
                e_tap  = t_lo + (t_hi - t_lo) / 2;
                e_up   = t_end;
                e_down = t_end - e_tap;
                e_cyc  = -1;
            end
`endif
        end
        if (oor_on && e_up > 0) begin
            e_done = 1'b0;
            e_tap  = 1;
            e_up   = 1;
            e_down = 0;
            e_slip = (t_lo == 0) ? p_lo : 7;
            e_cyc  = -1;
        end
    endtask

    task automatic run_train(input string nm, input int lo, input int hi, input int r0, input logic oor_on);
        logic e_done;
        int   e_tap, e_up, e_down, e_slip, e_cyc;
        int   b_load, b_up, b_down, b_slip, b_rst, b_bad, cycles;
        bit   seen;
        model(lo, hi, r0, oor_on, e_done, e_tap, e_up, e_down, e_slip, e_cyc);
        @(posedge clk); #1;
        win_lo  = lo;
        win_hi  = hi;
        rot_off = ((r0 - ch_slips) % 8 + 8) % 8;
        oor     = oor_on;
        b_load = n_load; b_up = n_up; b_down = n_down;
        b_slip = n_slip; b_rst = n_rstlow; b_bad = n_bad;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq({nm, ".busy_at_start"}, int'(busy), 1);
        check_eq({nm, ".cdd_rst_n_at_start"}, int'(cdd_rst_n), 0);
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < BUDGET) begin
            @(posedge clk); #1;
            cycles++;
            start = (cycles == 30);
            if (done || error) seen = 1'b1;
        end
        start = 1'b0;
        check_eq({nm, ".finished"}, int'(seen), 1);
        check_eq({nm, ".done"}, int'(done), int'(e_done));
        check_eq({nm, ".error"}, int'(error), int'(!e_done));
        check_eq({nm, ".tap"}, int'(tap), e_tap);
        check_eq({nm, ".moves_up"}, n_up - b_up, e_up);
        check_eq({nm, ".moves_down"}, n_down - b_down, e_down);
        check_eq({nm, ".slips"}, n_slip - b_slip, e_slip);
        check_eq({nm, ".loads"}, n_load - b_load, 1);
        check_eq({nm, ".rst_low_cycles"}, n_rstlow - b_rst, 8);
        check_eq({nm, ".pulse_overlap"}, n_bad - b_bad, 0);
        if (e_cyc >= 0) check_eq({nm, ".cycles"}, cycles, e_cyc);
        repeat (3) @(posedge clk);
        #1;
        check_eq({nm, ".status_held"}, int'({done, error, busy}), e_done ? 4 : 2);
    endtask

    initial begin
        int cycles;
        rst   = 1'b1;
        start = 1'b0;
        oor   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset.cdd_rst_n", int'(cdd_rst_n), 1);
        check_eq("reset.tap", int'(tap), 0);
        check_eq("reset.others", int'({load, move, dir, slip, busy, done, error}), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("idle.no_start", int'({busy, done, error}), 0);

        run_train("aligned", 0, 127, 0, 1'b0);
        run_train("slip_only", 0, 127, 5, 1'b0);
        run_train("tap_search", 5, 5, 3, 1'b0);
        run_train("window_10_20", 10, 20, int'($urandom_range(0, 7)), 1'b0);
        run_train("oor_ignored", 0, 127, 0, 1'b1);
        run_train("oor_after_move", 2, 4, 1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            int lo;
            lo = int'($urandom_range(0, 8));
            run_train($sformatf("rand%0d", i), lo, lo + int'($urandom_range(0, 6)),
                      int'($urandom_range(0, 7)), 1'b0);
        end
        run_train("never_matches", 200, 200, 0, 1'b0);

        // Abort a search at tap 3 with RESET, then retrain.
        @(posedge clk); #1;
        win_lo = 200;
        win_hi = 200;
        oor    = 1'b0;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        cycles = 0;
        while (ch_tap != 3 && cycles < BUDGET) begin
            @(posedge clk); #1;
            cycles++;
        end
        check_eq("midreset.reached_tap3", ch_tap, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("midreset.cdd_rst_n", int'(cdd_rst_n), 1);
        check_eq("midreset.tap", int'(tap), 0);
        check_eq("midreset.status", int'({busy, done, error, load, move, slip}), 0);
        repeat (5) @(posedge clk);
        #1;
        check_eq("midreset.stays_idle", int'({busy, cdd_rst_n}), 1);
        run_train("after_reset", 0, 127, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pf_clk_div_delay_ctrl.md
# pf_clk_div_delay_ctrl

Training controller for the PolarFire LVDS RX clock-divider/delay cell (ICB_CLKDIVDELAY) and its deserializer. It resets the divider, loads the delay line to tap 0, then searches delay taps and bit-slip positions until the deserialized word equals a fixed training pattern. It reports DONE or ERROR and sits beside the PF_IOD_LVDS_RX clock-divider wrapper, clocked by the divided clock.

## Interface
- DATA_WIDTH, 8: deserialized word width; also the number of bit-slip positions tried per tap.
- TRAIN_PATTERN, 8'hB4: expected word; must not equal any of its own rotations.
- MAX_TAPS, 128: highest tap index plus one; the TAP_COUNT width is 8.
- RST_CYCLES, 8: number of cycles CDD_RST_N is held low.
- SETTLE_CYCLES, 16: wait after any LOAD, MOVE or SLIP pulse before comparing.
- COMPARE_CYCLES, 32: number of consecutive matching words required for a pass.

Ports:
- CLK  in  1  divided clock (CLK_DIV_OUT domain).
- RESET  in  1  synchronous, active-high reset.
- START  in  1  level-sampled request to begin or restart training.
- RX_DATA  in  DATA_WIDTH  deserialized word, valid every cycle.
- DELAY_LINE_OUT_OF_RANGE  in  1  range flag from the cell.
- CDD_RST_N  out  1  drives the cell RST_N.
- DELAY_LINE_LOAD  out  1  one-cycle pulse.
- DELAY_LINE_MOVE  out  1  one-cycle pulse.
- DELAY_LINE_DIR  out  1  1 = increment tap, 0 = decrement; stable during MOVE.
- BIT_SLIP  out  1  one-cycle pulse.
- TAP_COUNT  out  8  current tap.
- BUSY, DONE, ERROR  out  1 each  status outputs.

## Operation
States: IDLE, CDD_RST, LOAD, SETTLE, COMPARE, SLIP, MOVE, DONE, ERROR. The states SCAN and BACK exist only when CENTER_EN is compiled in.

- **IDLE:** on START=1, go to CDD_RST. Clear the slip counter and set BUSY=1.
- **CDD_RST:** hold CDD_RST_N=0 for RST_CYCLES cycles, then go to LOAD.
- **LOAD:** pulse DELAY_LINE_LOAD for one cycle, set TAP_COUNT=0, then go to SETTLE.
- **SETTLE:** count SETTLE_CYCLES cycles, then go to COMPARE.
- **COMPARE:** count consecutive cycles where RX_DATA==TRAIN_PATTERN.
  - Reaching COMPARE_CYCLES is a pass: go to DONE.
  - Any mismatch is a fail: clear the match count and go to SLIP.
- **SLIP:**
  - If slip_cnt < DATA_WIDTH-1: pulse BIT_SLIP, increment slip_cnt, go to SETTLE.
  - Otherwise: clear slip_cnt and go to MOVE.
- **MOVE:**
  - If TAP_COUNT==MAX_TAPS-1: go to ERROR.
  - Otherwise: pulse MOVE with DIR=1, increment TAP_COUNT, go to SETTLE.
  - If DELAY_LINE_OUT_OF_RANGE=1 in the cycle after the MOVE pulse: go to ERROR.
- **DONE / ERROR:** the status bit is held and BUSY=0. START=1 restarts the sequence from CDD_RST.
- START is ignored while BUSY=1.
- TAP_COUNT saturates within [0, MAX_TAPS-1] and never wraps.
- DELAY_LINE_OUT_OF_RANGE is ignored outside the MOVE handling.

## Timing
- Reset values: CDD_RST_N=1, TAP_COUNT=0, and every other output 0. The state returns to IDLE and all counters clear.
- A RESET asserted mid-training aborts within the same edge. No pulse is emitted in the reset cycle.
- All outputs are registered.
- START sampled at edge n gives CDD_RST_N=0 from edge n+1.
- A pass in the shortest case costs RST_CYCLES + 1 + SETTLE_CYCLES + COMPARE_CYCLES cycles, which is 57 with the defaults.
- Each failed position costs at least SETTLE_CYCLES + 2 cycles.
- LOAD, MOVE and SLIP pulses are exactly 1 cycle long and never coincide.
- DONE and ERROR are mutually exclusive.

## Configuration
Macro: `PF_CDD_CTRL_CENTER_EN`.

**Defined:** on the first pass at tap T_lo, the controller enters SCAN instead of DONE.
- SCAN repeats MOVE(DIR=1), SETTLE, COMPARE until a fail or TAP_COUNT==MAX_TAPS-1.
- Define T_hi as the last passing tap and T_end as the current tap.
- BACK then issues T_end − (T_lo + (T_hi−T_lo)/2) MOVE pulses with DIR=0. The division floors. Each pulse is followed by SETTLE, and TAP_COUNT decrements per pulse.
- The controller then goes to DONE.

**Undefined:** a pass goes directly to DONE at the first passing tap. The SCAN and BACK logic is absent.

## Test plan
- **Aligned at start:** RX_DATA constantly 8'hB4, pulse START → DONE after 57 cycles, TAP_COUNT=0, no BIT_SLIP pulses.
- **Slip only:** the model aligns after 3 slips → exactly 3 BIT_SLIP pulses, 0 MOVE pulses, DONE, TAP_COUNT=0.
- **Tap search:** the model passes only at tap 5 with slip 2 → 5 MOVE pulses with DIR=1, DONE, TAP_COUNT=5.
- **Never matches:** RX_DATA=8'h00 → 127 MOVE pulses, ERROR=1, TAP_COUNT=127.
- **Reset mid-search:** RESET at tap 3 → next cycle state is IDLE, CDD_RST_N=1, TAP_COUNT=0, BUSY=0. Then START retrains cleanly.
- **Centering (CENTER_EN defined):** passing window is taps 10–20, first fail at 21 → 21−15=6 DIR=0 MOVE pulses, DONE, TAP_COUNT=15.
